// File: rtl/fp32_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider (y = a / b), radix-2 restoring,
// one quotient bit per cycle, flush-to-zero on inputs and outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | in_ready=1, waiting for operand handshake
// S_UNPACK | split fields, normalise dividend, classify special cases
// S_DIV    | 25 restoring iterations (24 quotient bits + guard)
// S_ROUND  | round-to-nearest-even, range check, register result
// S_DONE   | hold y/flags with out_valid=1 until consumer accepts
module fp32_div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y,
  output logic [3:0]            flags
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIV    = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } spec_t;

  localparam logic signed [9:0] LP_BIAS   = 10'(EXP_BIAS);
  localparam logic [4:0]        LP_LAST   = 5'd24;
  localparam logic [31:0]       LP_QNAN   = 32'h7FC0_0000;

  state_t             r_state;
  spec_t              r_spec;
  logic               r_dz;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [25:0]        r_rem;
  logic [24:0]        r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_y;
  logic [3:0]         r_flags;
  logic               r_out_valid;
  logic               r_in_ready;

  // Operand field extraction; exponent 0 is treated as zero (FTZ).
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [22:0]        w_fa;
  logic [22:0]        w_fb;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_nan;
  logic               w_b_nan;
  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic               w_ma_lt;
  logic signed [9:0]  w_e_raw;
  logic signed [9:0]  w_e_adj;
  spec_t              w_spec;
  logic               w_dz;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_ma     = {1'b1, w_fa};
  assign w_mb     = {1'b1, w_fb};
  assign w_ma_lt  = (w_ma < w_mb);
  assign w_e_raw  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + LP_BIAS;
  assign w_e_adj  = w_ma_lt ? (w_e_raw - 10'sd1) : w_e_raw;

  always_comb begin
    w_spec = SP_NONE;
    w_dz   = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec = SP_NAN;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec = SP_NAN;
    end else if (w_b_zero) begin
      w_spec = SP_INF;
      w_dz   = 1'b1;
    end else if (w_a_inf) begin
      w_spec = SP_INF;
    end else if (w_a_zero || w_b_inf) begin
      w_spec = SP_ZERO;
    end
  end

  // One restoring step: remainder never exceeds 2*mb, so 25 bits hold it.
  logic               w_rem_ge;
  logic [24:0]        w_rem_sub;

  assign w_rem_ge  = (r_rem >= {2'b00, r_mb});
  assign w_rem_sub = w_rem_ge ? 25'(r_rem - {2'b00, r_mb}) : r_rem[24:0];

  // Rounding: q[24:1] is the 1.23 mantissa, q[0] the guard bit.
  logic               w_sticky;
  logic               w_rnd_up;
  logic [24:0]        w_mant;
  logic               w_carry;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_exp_fin;
  logic               w_ovf;
  logic               w_unf;

  assign w_sticky  = (r_rem != 26'd0);
  assign w_rnd_up  = r_q[0] && (w_sticky || r_q[1]);
  assign w_mant    = {1'b0, r_q[24:1]} + {24'd0, w_rnd_up};
  assign w_carry   = w_mant[24];
  assign w_frac    = w_carry ? w_mant[23:1] : w_mant[22:0];
  assign w_exp_fin = r_exp + $signed({9'd0, w_carry});
  assign w_ovf     = (w_exp_fin >= 10'sd255);
  assign w_unf     = (w_exp_fin <= 10'sd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_spec      <= SP_NONE;
      r_dz        <= 1'b0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_mb        <= 24'd0;
      r_rem       <= 26'd0;
      r_q         <= 25'd0;
      r_cnt       <= 5'd0;
      r_y         <= 32'd0;
      r_flags     <= 4'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a[31:0];
            r_b        <= b[31:0];
            r_in_ready <= 1'b0;
            r_state    <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          r_sign  <= r_a[31] ^ r_b[31];
          r_exp   <= w_e_adj;
          r_mb    <= w_mb;
          r_rem   <= w_ma_lt ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
          r_q     <= 25'd0;
          r_cnt   <= 5'd0;
          r_spec  <= w_spec;
          r_dz    <= w_dz;
          r_state <= S_DIV;
        end

        S_DIV: begin
          r_rem <= {w_rem_sub, 1'b0};
          r_q   <= {r_q[23:0], w_rem_ge};
          if (r_cnt == LP_LAST) begin
            r_state <= S_ROUND;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end

        S_ROUND: begin
          case (r_spec)
            SP_NAN: begin
              r_y     <= LP_QNAN;
              r_flags <= 4'b1000;
            end
            SP_INF: begin
              r_y     <= {r_sign, 8'hFF, 23'd0};
              r_flags <= {1'b0, r_dz, 2'b00};
            end
            SP_ZERO: begin
              r_y     <= {r_sign, 31'd0};
              r_flags <= 4'b0000;
            end
            default: begin
              if (w_ovf) begin
                r_y     <= {r_sign, 8'hFF, 23'd0};
                r_flags <= 4'b0010;
              end else if (w_unf) begin
                r_y     <= {r_sign, 31'd0};
                r_flags <= 4'b0001;
              end else begin
                r_y     <= {r_sign, w_exp_fin[7:0], w_frac};
                r_flags <= 4'b0000;
              end
            end
          endcase
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = DATA_WIDTH'(r_y);
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed bench for fp32_div_seq: arithmetic, special cases, latency,
// backpressure, issue interval and mid-operation reset.
module tb_fp32_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  fp32_div_seq #(.DATA_WIDTH(32), .EXP_BIAS(127)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ey, input logic [3:0] ef);
    int lat;
    wait_ready();
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 27);
    check({tag, "_y"}, y, ey);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] hold_y;
    logic [3:0]  hold_f;
    int          t[3];
    int          nd;
    int          w;
    logic        seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("div6_3",    32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 4'b0000);
    run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000);
    run_op("neg_quart", 32'hBF80_0000, 32'h4080_0000, 32'hBE80_0000, 4'b0000);
    run_op("negsix_3",  32'hC0C0_0000, 32'h4040_0000, 32'hC000_0000, 4'b0000);
    run_op("div_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
    run_op("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
    run_op("inf_inf",   32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
    run_op("inf_fin",   32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 4'b0000);
    run_op("fin_inf",   32'h4040_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000);
    run_op("zero_fin",  32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 4'b0000);
    run_op("denorm_b",  32'hBF80_0000, 32'h0000_0001, 32'hFF80_0000, 4'b0100);
    run_op("overflow",  32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 4'b0010);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001);

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    wait_ready();
    a = 32'h3F80_0000; b = 32'h4040_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    hold_y = y; hold_f = flags;
    check("bp_y", hold_y, 32'h3EAA_AAAB);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 32'h40C0_0000; b = 32'h4040_0000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (i == 2 || i == 5 || i == 9) begin
        check("bp_hold_y", y, hold_y);
        check("bp_hold_f", {28'd0, flags}, {28'd0, hold_f});
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    check("bp_release_ov", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_no_ghost", {31'd0, seen}, 32'd0);

    // Back-to-back with out_ready high and in_valid held.
    a = 32'h40C0_0000; b = 32'h4040_0000; in_valid = 1'b1; out_ready = 1'b1;
    nd = 0; w = 0;
    while (nd < 3 && w < 200) begin
      @(posedge clk); #1;
      w++;
      if (out_valid) begin
        t[nd] = cyc;
        check("b2b_y", y, 32'h4000_0000);
        nd++;
        if (nd == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_count", nd, 3);
    if (nd == 3) begin
      check("b2b_gap1", t[1] - t[0], 29);
      check("b2b_gap2", t[2] - t[1], 29);
    end

    // Reset in the middle of DIV (counter = 12).
    wait_ready();
    a = 32'h3F80_0000; b = 32'h4040_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", y, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("mid_rst_flags", {28'd0, flags}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_stale", {31'd0, seen}, 32'd0);
    run_op("post_rst", 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
